// File: rtl/reflet_bus_responder.sv
// Memory-mapped word RAM responder for the Reflet CPU bus with one-cycle read latency.
// Define REFLET_RESP_CLEAR_EN to add the post-reset RAM zeroing sequence (CLEAR state, busy output).
module reflet_bus_responder #(
  parameter int                  wordsize  = 16,
  parameter logic [wordsize-1:0] base_addr = 16'h8000,
  parameter int                  size_log2 = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic                hit,
  output logic                busy,
  output logic                fault
);

  localparam int SHIFT      = $clog2(wordsize / 8);
  localparam int SPAN_SHIFT = size_log2 + SHIFT;
  localparam int DEPTH      = 2 ** size_log2;
  localparam logic [wordsize-1:0] LOW_MASK = wordsize'((1 << SHIFT) - 1);

  typedef enum logic {READY = 1'b0, CLEAR = 1'b1} state_t;

  state_t                state;
  logic [wordsize-1:0]   mem [DEPTH];
  logic [wordsize-1:0]   off;
  logic [size_log2-1:0]  idx;
  logic                  in_range;
  logic                  misaligned;
  logic                  cpu_we;
  logic                  clr_we;
  logic [size_log2-1:0]  clr_idx;

  // Stage p0: address decode of the current bus request
  assign off        = addr - base_addr;
  assign in_range   = (addr >= base_addr) && ((off >> SPAN_SHIFT) == '0);
  assign idx        = off[SHIFT +: size_log2];
  assign misaligned = |(off & LOW_MASK);
  assign cpu_we     = enable && write_en && (state == READY) && in_range;

`ifdef REFLET_RESP_CLEAR_EN
  state_t               state_next;
  logic [size_log2-1:0] cnt;
  logic [size_log2-1:0] cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // cnt parks on the last word once READY so the clear never restarts without reset
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clr_we     = 1'b0;
    if (enable && (state == CLEAR)) begin
      clr_we = 1'b1;
      if (cnt == size_log2'(DEPTH - 1)) state_next = READY;
      else                              cnt_next   = cnt + 1'b1;
    end
  end

  assign clr_idx = cnt;
  assign busy    = (state == CLEAR);
`else
  assign state   = READY;
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
  assign busy    = 1'b0;
`endif

  // RAM array carries no reset; zeroing is only done by the clear sequence
  always_ff @(posedge clk) begin
    if (clr_we)      mem[clr_idx] <= '0;
    else if (cpu_we) mem[idx]     <= data_in;
  end

  // Stage p1: registered response, write-first on the addressed word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      hit      <= 1'b0;
      fault    <= 1'b0;
    end else if (enable) begin
      if ((state == READY) && in_range) begin
        data_out <= write_en ? data_in : mem[idx];
        hit      <= 1'b1;
        if (misaligned) fault <= 1'b1;
      end else begin
        data_out <= '0;
        hit      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reflet_bus_responder.sv
// Scoreboard bench for reflet_bus_responder: a word-array reference model predicts each cycle's
// response; a monitor compares DUT outputs one cycle after each issued bus cycle.
module tb_reflet_bus_responder;

`ifdef REFLET_RESP_CLEAR_EN
  localparam int CLR_WORDS = 256;
`else
  localparam int CLR_WORDS = 0;
`endif
  localparam int BASE  = 32'h8000;
  localparam int BYTES = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        write_en;
  logic [15:0] data_out;
  logic        hit;
  logic        busy;
  logic        fault;

  always #5 clk = ~clk;

  reflet_bus_responder dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .addr     (addr),
    .data_in  (data_in),
    .write_en (write_en),
    .data_out (data_out),
    .hit      (hit),
    .busy     (busy),
    .fault    (fault)
  );

  typedef struct {
    logic [15:0] d;
    bit          dk;
    bit          h;
    bit          f;
    bit          b;
    int          tag;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          tests = 0;
  int          fails = 0;
  int          phase = 0;

  logic [15:0] mmem [256];
  bit          mknown [256];
  int          clr_left;
  int          clr_pos;
  logic [15:0] m_do;
  bit          m_dk;
  bit          m_h;
  bit          m_f;

  // Issue one bus cycle and predict the response visible after the next rising edge
  task automatic cyc(input bit en, input logic [15:0] a, input logic [15:0] d, input bit we);
    int ai;
    int idx;
    bit inr;
    @(negedge clk);
    enable = en; addr = a; data_in = d; write_en = we;
    ai  = int'(a);
    inr = (ai >= BASE) && (ai < BASE + BYTES);
    idx = (ai - BASE) / 2;
    if (en) begin
      if (clr_left > 0) begin
        mmem[clr_pos] = 16'h0000; mknown[clr_pos] = 1'b1;
        clr_pos++; clr_left--;
        m_do = 16'h0000; m_dk = 1'b1; m_h = 1'b0;
      end else if (inr) begin
        if (we) begin mmem[idx] = d; mknown[idx] = 1'b1; end
        m_do = mmem[idx]; m_dk = mknown[idx]; m_h = 1'b1;
        if ((ai % 2) != 0) m_f = 1'b1;
      end else begin
        m_do = 16'h0000; m_dk = 1'b1; m_h = 1'b0;
      end
    end
    q.push_back('{m_do, m_dk, m_h, m_f, (clr_left > 0), phase});
  endtask

  task automatic do_reset();
    @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses never observed, required 0", q.size());
      q.delete();
    end
    reset = 1'b1; enable = 1'b0; write_en = 1'b0;
    #1;
    tests++;
    if (data_out !== 16'h0000 || hit !== 1'b0 || fault !== 1'b0 || busy !== (CLR_WORDS > 0)) begin
      fails++;
      $display("FAIL reset_state: got do=%h hit=%b fault=%b busy=%b, required do=0000 hit=0 fault=0 busy=%0d",
               data_out, hit, fault, busy, (CLR_WORDS > 0));
    end
    m_do = 16'h0000; m_dk = 1'b1; m_h = 1'b0; m_f = 1'b0;
    clr_left = CLR_WORDS; clr_pos = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset && q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if (hit !== e.h || fault !== e.f || busy !== e.b || (e.dk && data_out !== e.d)) begin
        fails++;
        $display("FAIL response phase%0d t=%0t: got do=%h hit=%b fault=%b busy=%b, required do=%h(known=%0d) hit=%0d fault=%0d busy=%0d",
                 e.tag, $time, data_out, hit, fault, busy, e.d, e.dk, e.h, e.f, e.b);
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; addr = '0; data_in = '0; write_en = 1'b0;
    for (int i = 0; i < 256; i++) mknown[i] = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    phase = 1;
    if (CLR_WORDS > 0) begin
      // partial clear with frozen cycles and dropped writes, then reset mid-clear
      for (int i = 0; i < 100; i++) begin
        cyc(1'b1, 16'(BASE + 2 * $urandom_range(0, 255)), 16'($urandom), 1'b1);
        if (i % 17 == 0) cyc(1'b0, 16'h8010, 16'h5555, 1'b1);
      end
      do_reset();
      phase = 2;
      for (int i = 0; i < 256; i++)
        cyc(1'b1, (i == 40) ? 16'h8010 : 16'h8000, 16'hDEAD, (i == 40));
      phase = 3;
      for (int i = 0; i < 256; i++) cyc(1'b1, 16'(BASE + 2 * i), 16'h0000, 1'b0);
    end else begin
      for (int i = 0; i < 256; i++) cyc(1'b1, 16'(BASE + 2 * i), 16'($urandom), 1'b1);
    end

    phase = 4;
    cyc(1'b1, 16'h8010, 16'hBEEF, 1'b1);
    cyc(1'b1, 16'h8010, 16'h0000, 1'b0);
    cyc(1'b1, 16'h8002, 16'h1234, 1'b1);
    cyc(1'b1, 16'h8002, 16'h0000, 1'b0);
    cyc(1'b1, 16'h8200, 16'hFFFF, 1'b1);
    cyc(1'b1, 16'h7FFE, 16'h0000, 1'b0);
    cyc(1'b1, 16'h8200, 16'h0000, 1'b0);
    cyc(1'b1, 16'h81FE, 16'h0000, 1'b0);
    cyc(1'b1, 16'h8011, 16'h0000, 1'b0);
    cyc(1'b0, 16'h9000, 16'h7777, 1'b1);
    cyc(1'b0, 16'h8000, 16'h7777, 1'b1);
    cyc(1'b1, 16'h8000, 16'h0000, 1'b0);
    cyc(1'b1, 16'h7FFF, 16'h0000, 1'b0);
    cyc(1'b1, 16'hFFFE, 16'h0000, 1'b0);

    phase = 5;
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 9) != 0, 16'(32'h7FF0 + $urandom_range(0, 32'h220)),
          16'($urandom), $urandom_range(0, 2) == 0);

    phase = 6;
    do_reset();
    cyc(1'b1, 16'h8100, 16'h0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL final_drain: %0d responses never observed, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
